// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - VGA timing outputs bundled for the pixel generator stage
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       f_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;

  modport master (
    output hsync, vsync, video_on, p_tick, f_tick, pix_x, pix_y
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, f_tick, pix_x, pix_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator with pixel-rate divider
// Sync and blanking are registered from next-state counters so they align with pix_x/pix_y.
module vga_sync_gen #(
  parameter int CLK_DIV = 2,
  parameter int HD      = 640,
  parameter int HF      = 16,
  parameter int HR      = 96,
  parameter int HB      = 48,
  parameter int VD      = 480,
  parameter int VF      = 10,
  parameter int VR      = 2,
  parameter int VB      = 33
) (
  input  logic            CLK,
  input  logic            RESET,
  vga_sync_gen_if.master  vga
);
  localparam int H_TOTAL = HD + HF + HR + HB;
  localparam int V_TOTAL = VD + VF + VR + VB;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             h_last;
  logic             v_last;

  assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (tick) begin
      if (h_last) begin
        h_next = 10'd0;
        v_next = v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt      <= '0;
      h_cnt        <= 10'd0;
      v_cnt        <= 10'd0;
      vga.hsync    <= 1'b1;
      vga.vsync    <= 1'b1;
      vga.video_on <= 1'b0;
      vga.p_tick   <= 1'b0;
      vga.f_tick   <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);
      h_cnt        <= h_next;
      v_cnt        <= v_next;
      // Sync pulses are active low inside the retrace window.
      vga.hsync    <= !((h_next >= 10'(HD + HF)) && (h_next <= 10'(HD + HF + HR - 1)));
      vga.vsync    <= !((v_next >= 10'(VD + VF)) && (v_next <= 10'(VD + VF + VR - 1)));
      vga.video_on <= (h_next < 10'(HD)) && (v_next < 10'(VD));
      vga.p_tick   <= tick;
      vga.f_tick   <= tick && h_last && v_last;
    end
  end

  assign vga.pix_x = h_cnt;
  assign vga.pix_y = v_cnt;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench: full-size timing plus a scaled CLK_DIV=1 frame
module tb_vga_sync_gen;
  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  vga_sync_gen_if vf ();
  vga_sync_gen_if vs ();

  vga_sync_gen #(.CLK_DIV(2)) u_full (.CLK(CLK), .RESET(RESET), .vga(vf));

  vga_sync_gen #(.CLK_DIV(1), .HD(8), .HF(2), .HR(3), .HB(3),
                 .VD(6), .VF(2), .VR(2), .VB(2)) u_small (.CLK(CLK), .RESET(RESET), .vga(vs));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  int q_f[$];
  int q_s[$];
  int last_tick_f = -1;
  int last_tick_s = -1;
  int last_frame_s = -1;
  int hs_low = 0;

  function automatic int pack(int x, int y, bit hs, bit vsy, bit von, bit ft);
    return (x << 14) | (y << 4) | (int'(hs) << 3) | (int'(vsy) << 2) | (int'(von) << 1) | int'(ft);
  endfunction

  // Reference: pixel index n after the n-th tick, decomposed into scan position.
  function automatic int model(int n, int hd, int hf, int hr, int hb,
                               int vd, int vfp, int vr, int vb);
    int ht, vt, x, y;
    ht = hd + hf + hr + hb;
    vt = vd + vfp + vr + vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    return pack(x, y, !(x >= hd + hf && x < hd + hf + hr), !(y >= vd + vfp && y < vd + vfp + vr),
                (x < hd) && (y < vd), (n > 0) && (n % (ht * vt) == 0));
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int act_of(int x, int y, bit hs, bit vsy, bit von, bit ft);
    return pack(x, y, hs, vsy, von, ft);
  endfunction

  always @(negedge CLK) begin
    if (vf.p_tick && q_f.size() > 0) begin
      chk("full_scan", act_of(vf.pix_x, vf.pix_y, vf.hsync, vf.vsync, vf.video_on, vf.f_tick),
          q_f.pop_front());
      if (last_tick_f >= 0) chk("full_ptick_gap", cyc - last_tick_f, 2);
      last_tick_f = cyc;
    end
    if (!vf.hsync) hs_low++;
    else if (hs_low > 0) begin
      chk("hsync_low_clks", hs_low, 192);
      hs_low = 0;
    end
  end

  always @(negedge CLK) begin
    if (vs.p_tick && q_s.size() > 0) begin
      chk("small_scan", act_of(vs.pix_x, vs.pix_y, vs.hsync, vs.vsync, vs.video_on, vs.f_tick),
          q_s.pop_front());
      if (last_tick_s >= 0) chk("small_ptick_gap", cyc - last_tick_s, 1);
      last_tick_s = cyc;
      if (vs.f_tick) begin
        if (last_frame_s >= 0) chk("small_frame_gap", cyc - last_frame_s, 192);
        last_frame_s = cyc;
      end
    end
  end

  task automatic chk_reset_state(string name);
    chk(name, act_of(vf.pix_x, vf.pix_y, vf.hsync, vf.vsync, vf.video_on, vf.f_tick),
        pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0));
    chk({name, "_ptick"}, int'(vf.p_tick), 0);
    chk({name, "_small"}, act_of(vs.pix_x, vs.pix_y, vs.hsync, vs.vsync, vs.video_on, vs.f_tick),
        pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    int k;
    RESET = 1'b1;
    for (int n = 1; n <= 2700; n++) q_f.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
    for (int n = 1; n <= 400; n++)  q_s.push_back(model(n, 8, 2, 3, 3, 6, 2, 2, 2));
    repeat (3) @(negedge CLK);
    chk_reset_state("reset_state");

    RESET = 1'b0;
    @(negedge CLK);
    chk("first_edge_video_on", int'(vf.video_on), 1);
    chk("first_edge_ptick", int'(vf.p_tick), 0);

    k = 0;
    while ((q_f.size() > 0 || q_s.size() > 0) && k < 5600) begin
      @(negedge CLK);
      k++;
    end
    chk("drain_full_left", q_f.size(), 0);
    chk("drain_small_left", q_s.size(), 0);
    chk("pre_reset_pos", act_of(vf.pix_x, vf.pix_y, 1'b0, 1'b0, 1'b0, 1'b0),
        pack(300, 3, 1'b0, 1'b0, 1'b0, 1'b0));

    RESET = 1'b1;
    last_tick_f = -1;
    @(negedge CLK);
    chk_reset_state("midframe_reset");
    for (int n = 1; n <= 20; n++) q_f.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33));
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("restart_ptick_cyc1", int'(vf.p_tick), 0);
    chk("restart_video_on", int'(vf.video_on), 1);
    @(negedge CLK);
    chk("restart_ptick_cyc2", int'(vf.p_tick), 1);
    k = 0;
    while (q_f.size() > 0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("restart_drain_left", q_f.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
